// File: rtl/rv32i_pkg.sv
// Shared widths, opcodes, ALU operation encoding and pipeline-register layouts
// for the Decode-to-Memory slice of the RV32I pipeline.
package rv32i_pkg;

    localparam int DPW = 32;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_IMM   = 7'd19;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic             regwrite;
        logic             resultsrc;
        logic             memwrite;
        logic             use_imm;
        logic             is_r;
        logic             is_mem;
        logic [2:0]       funct3;
        logic             funct7b5;
        logic [DPW-1:0]   rs1_val;
        logic [DPW-1:0]   rs2_val;
        logic [DPW-1:0]   imm;
        logic [4:0]       rd;
    } de_reg_t;

    typedef struct packed {
        logic             regwrite;
        logic             resultsrc;
        logic             memwrite;
        logic [DPW-1:0]   aluresult;
        logic [DPW-1:0]   rd2;
        logic [4:0]       rd;
    } em_reg_t;

    // Loads and stores always compute an address, whatever their funct3 says.
    function automatic alu_op_e alu_op_sel(input logic       is_mem,
                                           input logic       is_r,
                                           input logic [2:0] funct3,
                                           input logic       funct7b5);
        alu_op_e op;
        op = ALU_ADD;
        if (!is_mem) begin
            case (funct3)
                3'd0: op = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
                3'd1: op = ALU_SLL;
                3'd2: op = ALU_SLT;
                3'd3: op = ALU_SLTU;
                3'd4: op = ALU_XOR;
                3'd5: op = funct7b5 ? ALU_SRA : ALU_SRL;
                3'd6: op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU; shifts use b[4:0], compares return 0 or 1.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [DPW-1:0] a,
    input  logic [DPW-1:0] b,
    input  alu_op_e        op,
    output logic [DPW-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = ($signed(a) < $signed(b)) ? DPW'(1) : '0;
            ALU_SLTU: result = (a < b) ? DPW'(1) : '0;
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_top.sv
// Decode/Execute slice of an RV32I pipeline: decode, register read, immediate
// generation and ALU, registered through D/E and E/M to the Memory-stage outputs.
module rv32i_top
    import rv32i_pkg::*;
#(
    parameter int ADW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DPW-1:0] instrD,
    output logic           regwriteM,
    output logic           resultsrcM,
    output logic           memwriteM,
    output logic [DPW-1:0] aluresultM,
    output logic [DPW-1:0] Rd2M,
    output logic [4:0]     RdM
);

    localparam int NREG = 1 << ADW;

    logic [DPW-1:0] regs [NREG];
    logic [ADW-1:0] rs1_addr;
    logic [ADW-1:0] rs2_addr;
    logic [DPW-1:0] rs1_rd;
    logic [DPW-1:0] rs2_rd;

    logic [6:0]     opcode;
    logic [DPW-1:0] imm_i;
    logic [DPW-1:0] imm_s;
    logic           dec_valid;

    de_reg_t        de_next;
    de_reg_t        de_q;
    em_reg_t        em_next;
    em_reg_t        em_q;

    logic [DPW-1:0] alu_b;
    logic [DPW-1:0] alu_y;
    alu_op_e        alu_op;

    // Nothing writes the register file, so it only ever holds its reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= DPW'(i);
            end
        end else begin
            regs <= regs;
        end
    end

    assign rs1_addr = ADW'(instrD[19:15]);
    assign rs2_addr = ADW'(instrD[24:20]);
    assign rs1_rd   = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_rd   = (rs2_addr == '0) ? '0 : regs[rs2_addr];

    assign opcode = instrD[6:0];
    assign imm_i  = {{(DPW-12){instrD[31]}}, instrD[31:20]};
    assign imm_s  = {{(DPW-12){instrD[31]}}, instrD[31:25], instrD[11:7]};

    // Unknown opcodes become an all-zero bubble, which the ALU turns into 0 + 0.
    always_comb begin
        de_next   = '0;
        dec_valid = 1'b1;
        case (opcode)
            OP_LOAD: begin
                de_next.regwrite  = 1'b1;
                de_next.resultsrc = 1'b1;
                de_next.use_imm   = 1'b1;
                de_next.is_mem    = 1'b1;
                de_next.imm       = imm_i;
            end
            OP_IMM: begin
                de_next.regwrite  = 1'b1;
                de_next.use_imm   = 1'b1;
                de_next.imm       = imm_i;
            end
            OP_STORE: begin
                de_next.memwrite  = 1'b1;
                de_next.use_imm   = 1'b1;
                de_next.is_mem    = 1'b1;
                de_next.imm       = imm_s;
            end
            OP_R: begin
                de_next.regwrite  = 1'b1;
                de_next.is_r      = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
        if (dec_valid) begin
            de_next.rs1_val  = rs1_rd;
            de_next.rs2_val  = rs2_rd;
            de_next.funct3   = instrD[14:12];
            de_next.funct7b5 = instrD[30];
            de_next.rd       = instrD[11:7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q <= '0;
        end else begin
            de_q <= de_next;
        end
    end

    assign alu_op = alu_op_sel(de_q.is_mem, de_q.is_r, de_q.funct3, de_q.funct7b5);
    assign alu_b  = de_q.use_imm ? de_q.imm : de_q.rs2_val;

    rv32i_alu u_alu (
        .a      (de_q.rs1_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_y)
    );

    always_comb begin
        em_next           = '0;
        em_next.regwrite  = de_q.regwrite;
        em_next.resultsrc = de_q.resultsrc;
        em_next.memwrite  = de_q.memwrite;
        em_next.aluresult = alu_y;
        em_next.rd2       = de_q.rs2_val;
        em_next.rd        = de_q.rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_q <= '0;
        end else begin
            em_q <= em_next;
        end
    end

    assign regwriteM  = em_q.regwrite;
    assign resultsrcM = em_q.resultsrc;
    assign memwriteM  = em_q.memwrite;
    assign aluresultM = em_q.aluresult;
    assign Rd2M       = em_q.rd2;
    assign RdM        = em_q.rd;

endmodule

// File: tb/tb_rv32i_top.sv
// Directed bench for rv32i_top: reset state, a back-to-back instruction stream
// with hand-computed Memory-stage results, and an asynchronous mid-stream reset.
module tb_rv32i_top;

    logic        clk;
    logic        rst_n;
    logic [31:0] instrD;
    logic        regwriteM;
    logic        resultsrcM;
    logic        memwriteM;
    logic [31:0] aluresultM;
    logic [31:0] Rd2M;
    logic [4:0]  RdM;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] ins;
        logic        rw;
        logic        rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  rd;
    } vec_t;

    vec_t v[$];

    rv32i_top #(.ADW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instrD     (instrD),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .aluresultM (aluresultM),
        .Rd2M       (Rd2M),
        .RdM        (RdM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'd51};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'd35};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_m(input string tag, input logic rw, input logic rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd);
        chk({tag, ".regwrite"},  {31'd0, regwriteM},  {31'd0, rw});
        chk({tag, ".resultsrc"}, {31'd0, resultsrcM}, {31'd0, rs});
        chk({tag, ".memwrite"},  {31'd0, memwriteM},  {31'd0, mw});
        chk({tag, ".aluresult"}, aluresultM, alu);
        chk({tag, ".rd2"},       Rd2M, rd2);
        chk({tag, ".rd"},        {27'd0, RdM}, {27'd0, rd});
    endtask

    task automatic cyc(input logic [31:0] ins);
        @(negedge clk);
        instrD = ins;
    endtask

    initial begin
        rst_n  = 1'b0;
        instrD = rtype(7'h00, 5'd15, 5'd3, 3'd0, 5'd7);
        #1;
        chk_m("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(posedge clk);
        #1;
        chk_m("reset_held", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        v.push_back('{rtype(7'h00, 5'd15, 5'd3, 3'd0, 5'd7),  1'b1, 1'b0, 1'b0, 32'd18, 32'd15, 5'd7});
        v.push_back('{rtype(7'h20, 5'd15, 5'd3, 3'd0, 5'd7),  1'b1, 1'b0, 1'b0, 32'hFFFFFFF4, 32'd15, 5'd7});
        v.push_back('{itype(12'd12, 5'd5, 3'd0, 5'd1, 7'd19), 1'b1, 1'b0, 1'b0, 32'd17, 32'd12, 5'd1});
        v.push_back('{itype(12'h402, 5'd10, 3'd5, 5'd3, 7'd19), 1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 5'd3});
        v.push_back('{itype(12'd20, 5'd10, 3'd2, 5'd9, 7'd3), 1'b1, 1'b1, 1'b0, 32'd30, 32'd20, 5'd9});
        v.push_back('{stype(12'd4, 5'd11, 5'd2, 3'd2),        1'b0, 1'b0, 1'b1, 32'd6, 32'd11, 5'd4});
        v.push_back('{{7'h20, 5'd15, 5'd3, 3'd0, 5'd7, 7'h7F}, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0});
        v.push_back('{rtype(7'h00, 5'd4, 5'd3, 3'd1, 5'd2),   1'b1, 1'b0, 1'b0, 32'd48, 32'd4, 5'd2});
        v.push_back('{rtype(7'h00, 5'd15, 5'd3, 3'd2, 5'd5),  1'b1, 1'b0, 1'b0, 32'd1, 32'd15, 5'd5});
        v.push_back('{rtype(7'h00, 5'd2, 5'd3, 3'd3, 5'd6),   1'b1, 1'b0, 1'b0, 32'd0, 32'd2, 5'd6});
        v.push_back('{rtype(7'h00, 5'd15, 5'd3, 3'd4, 5'd8),  1'b1, 1'b0, 1'b0, 32'd12, 32'd15, 5'd8});
        v.push_back('{rtype(7'h00, 5'd2, 5'd31, 3'd5, 5'd10), 1'b1, 1'b0, 1'b0, 32'd7, 32'd2, 5'd10});
        v.push_back('{rtype(7'h00, 5'd5, 5'd3, 3'd6, 5'd11),  1'b1, 1'b0, 1'b0, 32'd7, 32'd5, 5'd11});
        v.push_back('{rtype(7'h00, 5'd5, 5'd3, 3'd7, 5'd12),  1'b1, 1'b0, 1'b0, 32'd1, 32'd5, 5'd12});
        v.push_back('{itype(12'hFFF, 5'd0, 3'd0, 5'd13, 7'd19), 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd31, 5'd13});
        v.push_back('{itype(12'hFFF, 5'd3, 3'd2, 5'd14, 7'd19), 1'b1, 1'b0, 1'b0, 32'd0, 32'd31, 5'd14});
        v.push_back('{itype(12'hFFF, 5'd3, 3'd3, 5'd15, 7'd19), 1'b1, 1'b0, 1'b0, 32'd1, 32'd31, 5'd15});
        v.push_back('{stype(12'hFFC, 5'd7, 5'd10, 3'd2),      1'b0, 1'b0, 1'b1, 32'd6, 32'd7, 5'd28});
        v.push_back('{rtype(7'h00, 5'd5, 5'd0, 3'd0, 5'd16),  1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 5'd16});
        v.push_back('{rtype(7'h20, 5'd0, 5'd9, 3'd0, 5'd17),  1'b1, 1'b0, 1'b0, 32'd9, 32'd0, 5'd17});
        v.push_back('{itype(12'h003, 5'd31, 3'd5, 5'd18, 7'd19), 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 5'd18});
        v.push_back('{itype(12'h400, 5'd1, 3'd0, 5'd19, 7'd19), 1'b1, 1'b0, 1'b0, 32'd1025, 32'd0, 5'd19});
        v.push_back('{itype(12'hFF8, 5'd20, 3'd2, 5'd21, 7'd3), 1'b1, 1'b1, 1'b0, 32'd12, 32'd24, 5'd21});

        // One instruction per cycle; outputs at each negedge belong to the one driven two negedges earlier.
        for (int i = 0; i < v.size() + 2; i++) begin
            cyc((i < v.size()) ? v[i].ins : 32'd0);
            if (i >= 2) begin
                chk_m($sformatf("vec%0d", i - 2), v[i-2].rw, v[i-2].rs, v[i-2].mw,
                      v[i-2].alu, v[i-2].rd2, v[i-2].rd);
            end
        end

        cyc(rtype(7'h00, 5'd15, 5'd3, 3'd0, 5'd7));
        cyc(stype(12'd4, 5'd11, 5'd2, 3'd2));
        cyc(itype(12'h402, 5'd10, 3'd5, 5'd3, 7'd19));
        chk("pre_rst.aluresult", aluresultM, 32'd18);
        @(posedge clk);
        #2;
        chk("pre_rst.memwrite", {31'd0, memwriteM}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_m("async_rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        instrD = itype(12'd12, 5'd5, 3'd0, 5'd1, 7'd19);
        cyc(32'd0);
        chk_m("post_rst_bubble", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        cyc(32'd0);
        chk_m("post_rst_first", 1'b1, 1'b0, 1'b0, 32'd17, 32'd12, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
